// File: rtl/move_collector_if.sv
// Handshake and data bundle between the move-generation array, the software
// request port and the move_collector sequencing stage.
interface move_collector_if;
    logic        start;
    logic [5:0]  square_in;
    logic [3:0]  piece_in;
    logic        init;
    logic [5:0]  square_calc;
    logic [3:0]  piece_type_calc;
    logic [63:0] movebits;
    logic [63:0] occupied_map;
    logic        move_valid;
    logic [5:0]  move_square;
    logic        move_ready;
    logic        done;
    logic [6:0]  move_count;
    logic        busy;

    // Collector side: consumes requests and array results, produces the move stream.
    modport slave (
        input  start, square_in, piece_in, movebits, occupied_map, move_ready,
        output init, square_calc, piece_type_calc, move_valid, move_square,
               done, move_count, busy
    );

    // Requester / array / stream-consumer side.
    modport master (
        output start, square_in, piece_in, movebits, occupied_map, move_ready,
        input  init, square_calc, piece_type_calc, move_valid, move_square,
               done, move_count, busy
    );
endinterface

// File: rtl/move_collector.sv
// Sequences one move-generation request through the 64-square array, adds the
// pawn double step and streams legal targets out in ascending square order.
module move_collector #(
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    move_collector_if.slave  bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SCAN   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [3:0] PIECE_BPAWN = 4'd5;
    localparam logic [3:0] PIECE_WPAWN = 4'd11;
    localparam logic [3:0] PIECE_LIMIT = 4'd12;
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [2:0]  state;
    logic [5:0]  square_calc;
    logic [3:0]  piece_type_calc;
    logic [6:0]  move_count;
    logic [7:0]  settle_cnt;
    logic [63:0] remaining;
    logic [63:0] dbl;
    logic [63:0] remaining_next;
    logic [5:0]  low_idx;
    logic [5:0]  one_step;
    logic [5:0]  two_step;
    logic        pawn_on_home;
    logic        move_valid;
    logic        handshake;

    // Double step only from the pawn's home rank, through an empty square that
    // the array already reported reachable, onto an unoccupied target.
    always_comb begin
        dbl          = '0;
        one_step     = '0;
        two_step     = '0;
        pawn_on_home = 1'b0;
        if (piece_type_calc == PIECE_WPAWN && square_calc[5:3] == 3'd1) begin
            pawn_on_home = 1'b1;
            one_step     = square_calc + 6'd8;
            two_step     = square_calc + 6'd16;
        end else if (piece_type_calc == PIECE_BPAWN && square_calc[5:3] == 3'd6) begin
            pawn_on_home = 1'b1;
            one_step     = square_calc - 6'd8;
            two_step     = square_calc - 6'd16;
        end
        if (pawn_on_home && bus.movebits[one_step] && !bus.occupied_map[two_step]) begin
            dbl[two_step] = 1'b1;
        end
    end

    always_comb begin
        low_idx = '0;
        for (int unsigned i = 64; i > 0; i--) begin
            if (remaining[i-1]) begin
                low_idx = 6'(i - 1);
            end
        end
    end

    assign move_valid     = (state == ST_SCAN) && (|remaining);
    assign handshake      = move_valid && bus.move_ready;
    // Clearing the lowest set bit is exactly the bit that low_idx points at.
    assign remaining_next = remaining & (remaining - 64'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            square_calc     <= '0;
            piece_type_calc <= '0;
            move_count      <= '0;
            settle_cnt      <= '0;
            remaining       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        square_calc     <= bus.square_in;
                        piece_type_calc <= bus.piece_in;
                        move_count      <= '0;
                        state           <= (bus.piece_in >= PIECE_LIMIT) ? ST_DONE : ST_INIT;
                    end
                end
                ST_INIT: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        remaining <= bus.movebits | dbl;
                        state     <= ST_SCAN;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                ST_SCAN: begin
                    if (remaining == '0) begin
                        state <= ST_DONE;
                    end else if (handshake) begin
                        remaining  <= remaining_next;
                        move_count <= move_count + 7'd1;
                        if (remaining_next == '0) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.init            = (state == ST_INIT);
    assign bus.done            = (state == ST_DONE);
    assign bus.busy            = (state != ST_IDLE);
    assign bus.square_calc     = square_calc;
    assign bus.piece_type_calc = piece_type_calc;
    assign bus.move_count      = move_count;
    assign bus.move_valid      = move_valid;
    assign bus.move_square     = low_idx;

endmodule

// File: tb/tb_move_collector.sv
// Self-checking bench for move_collector: directed vector table, hand-written
// reset / invalid-piece sequences and randomized requests against a set model.
module tb_move_collector;

    localparam int S = 8;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    move_collector_if bus ();

    move_collector #(.SETTLE_CYCLES(S)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  sq;
        logic [3:0]  pc;
        logic [63:0] mb;
        logic [63:0] occ;
        int          ready_low;
        int          busy_start;
        logic [63:0] exp_mask;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Target set from the movement rules: everything the array reports, plus a
    // two-rank pawn advance from the home rank when the path and target allow.
    function automatic logic [63:0] ref_mask(input int sq, input int pc,
                                             input logic [63:0] mb, input logic [63:0] occ);
        logic [63:0] m;
        int rank;
        m    = mb;
        rank = sq / 8;
        if (pc == 11 && rank == 1 && mb[sq + 8] && !occ[sq + 16]) m[sq + 16] = 1'b1;
        if (pc == 5  && rank == 6 && mb[sq - 8] && !occ[sq - 16]) m[sq - 16] = 1'b1;
        return m;
    endfunction

    task automatic run_req(input logic [5:0] sq, input logic [3:0] pc,
                           input logic [63:0] mb, input logic [63:0] occ,
                           input logic [63:0] exp_mask, input int ready_low,
                           input bit rnd_ready, input int busy_start);
        int q[$];
        int n_exp, idx, stalls, forced, init_cnt, init_cyc, first_valid, done_cyc, exp_done;
        bit seq_ok, hold_ok, calc_ok, prev_stall, rdy;
        logic [5:0] prev_sq;
        logic [6:0] cnt_at_done;

        for (int i = 0; i < 64; i++) if (exp_mask[i]) q.push_back(i);
        n_exp = q.size();
        idx = 0; stalls = 0; forced = 0; init_cnt = 0; init_cyc = -1;
        first_valid = -1; done_cyc = -1; cnt_at_done = '0;
        seq_ok = 1; hold_ok = 1; calc_ok = 1; prev_stall = 0; prev_sq = '0;

        bus.square_in    = sq;
        bus.piece_in     = pc;
        bus.movebits     = mb;
        bus.occupied_map = occ;
        bus.move_ready   = 1'b0;
        bus.start        = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.square_in = 6'($urandom);
        bus.piece_in  = 4'($urandom);

        for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
            if (bus.init) begin
                init_cnt++;
                init_cyc = c;
            end
            if (bus.square_calc !== sq || bus.piece_type_calc !== pc) calc_ok = 0;
            if (prev_stall && (!bus.move_valid || bus.move_square !== prev_sq)) hold_ok = 0;
            if (c == busy_start) begin
                bus.start     = 1'b1;
                bus.square_in = 6'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.move_valid && forced < ready_low) begin
                rdy = 0;
                forced++;
            end else begin
                rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            bus.move_ready = rdy;
            if (bus.move_valid) begin
                if (first_valid < 0) first_valid = c;
                if (rdy) begin
                    if (idx >= n_exp || int'(bus.move_square) != q[idx]) seq_ok = 0;
                    idx++;
                end else begin
                    stalls++;
                end
            end
            prev_stall = bus.move_valid && !rdy;
            prev_sq    = bus.move_square;
            if (bus.done) begin
                done_cyc    = c;
                cnt_at_done = bus.move_count;
            end
            tick();
        end
        bus.start      = 1'b0;
        bus.move_ready = 1'b0;

        exp_done = (n_exp == 0) ? S + 3 : S + 2 + n_exp + stalls;
        check("done_cycle", done_cyc, exp_done);
        check("init_cycle", init_cyc, 1);
        check("init_count", init_cnt, 1);
        check("first_valid", first_valid, (n_exp == 0) ? -1 : S + 2);
        check("move_sequence", {63'd0, seq_ok && idx == n_exp}, 64'd1);
        check("count_at_done", cnt_at_done, n_exp);
        check("square_hold", {63'd0, hold_ok}, 64'd1);
        check("calc_stable", {63'd0, calc_ok}, 64'd1);
        check("idle_after_done", bus.busy, 0);
        check("count_held", bus.move_count, n_exp);
        check("square_calc_held", bus.square_calc, sq);
    endtask

    initial begin
        logic [5:0]  rsq;
        logic [3:0]  rpc;
        logic [63:0] rmb, rocc;
        int done_cnt, done_cyc, init_cnt, valid_seen;
        bit seen;

        checks = 0;
        errors = 0;

        vecs[0]  = '{sq: 6'd0,  pc: 4'd8,  mb: (64'd1 << 10) | (64'd1 << 17), occ: 64'd0,
                     ready_low: 0, busy_start: 0, exp_mask: (64'd1 << 10) | (64'd1 << 17)};
        vecs[1]  = '{sq: 6'd12, pc: 4'd11, mb: 64'd1 << 20, occ: 64'd0,
                     ready_low: 0, busy_start: 0, exp_mask: (64'd1 << 20) | (64'd1 << 28)};
        vecs[2]  = '{sq: 6'd12, pc: 4'd11, mb: 64'd1 << 20, occ: 64'd1 << 28,
                     ready_low: 0, busy_start: 0, exp_mask: 64'd1 << 20};
        vecs[3]  = '{sq: 6'd27, pc: 4'd3,  mb: (64'd1 << 0) | (64'd1 << 63), occ: 64'd0,
                     ready_low: 5, busy_start: 0, exp_mask: (64'd1 << 0) | (64'd1 << 63)};
        vecs[4]  = '{sq: 6'd5,  pc: 4'd0,  mb: 64'd0, occ: 64'd0,
                     ready_low: 0, busy_start: 0, exp_mask: 64'd0};
        vecs[5]  = '{sq: 6'd52, pc: 4'd5,  mb: 64'd1 << 44, occ: 64'd0,
                     ready_low: 0, busy_start: 0, exp_mask: (64'd1 << 44) | (64'd1 << 36)};
        vecs[6]  = '{sq: 6'd52, pc: 4'd5,  mb: 64'd0, occ: 64'd0,
                     ready_low: 0, busy_start: 0, exp_mask: 64'd0};
        vecs[7]  = '{sq: 6'd20, pc: 4'd11, mb: 64'd1 << 28, occ: 64'd0,
                     ready_low: 0, busy_start: 0, exp_mask: 64'd1 << 28};
        vecs[8]  = '{sq: 6'd12, pc: 4'd5,  mb: 64'd1 << 20, occ: 64'd0,
                     ready_low: 0, busy_start: 0, exp_mask: 64'd1 << 20};
        vecs[9]  = '{sq: 6'd15, pc: 4'd11, mb: 64'd1 << 23, occ: 64'd0,
                     ready_low: 0, busy_start: 0, exp_mask: (64'd1 << 23) | (64'd1 << 31)};
        vecs[10] = '{sq: 6'd36, pc: 4'd4,  mb: '1, occ: 64'd0,
                     ready_low: 0, busy_start: 0, exp_mask: '1};
        vecs[11] = '{sq: 6'd9,  pc: 4'd2,  mb: (64'd1 << 3) | (64'd1 << 24), occ: 64'd0,
                     ready_low: 0, busy_start: 4, exp_mask: (64'd1 << 3) | (64'd1 << 24)};

        reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.square_in    = '0;
        bus.piece_in     = '0;
        bus.movebits     = '0;
        bus.occupied_map = '0;
        bus.move_ready   = 1'b0;
        #12;
        check("reset_init", bus.init, 0);
        check("reset_square_calc", bus.square_calc, 0);
        check("reset_piece_calc", bus.piece_type_calc, 0);
        check("reset_valid", bus.move_valid, 0);
        check("reset_move_square", bus.move_square, 0);
        check("reset_done", bus.done, 0);
        check("reset_count", bus.move_count, 0);
        check("reset_busy", bus.busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 12; v++) begin
            run_req(vecs[v].sq, vecs[v].pc, vecs[v].mb, vecs[v].occ, vecs[v].exp_mask,
                    vecs[v].ready_low, 1'b0, vecs[v].busy_start);
            tick();
        end

        // Invalid piece: straight to the end of the request without an array cycle.
        bus.square_in = 6'd9;
        bus.piece_in  = 4'd13;
        bus.movebits  = '1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        done_cnt = 0; done_cyc = -1; init_cnt = 0; valid_seen = 0;
        check("invalid_piece_calc", bus.piece_type_calc, 13);
        for (int c = 1; c <= 6; c++) begin
            if (bus.init) init_cnt++;
            if (bus.move_valid) valid_seen++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                check("invalid_count", bus.move_count, 0);
            end
            tick();
        end
        check("invalid_no_init", init_cnt, 0);
        check("invalid_no_valid", valid_seen, 0);
        check("invalid_done_once", done_cnt, 1);
        check("invalid_done_early", {63'd0, done_cyc >= 1 && done_cyc <= 2}, 64'd1);

        // Reset while a move is being offered.
        bus.square_in    = 6'd0;
        bus.piece_in     = 4'd8;
        bus.movebits     = (64'd1 << 3) | (64'd1 << 9) | (64'd1 << 40);
        bus.occupied_map = '0;
        bus.move_ready   = 1'b0;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (bus.move_valid) seen = 1;
            else tick();
        end
        check("pre_reset_valid", {63'd0, seen}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", bus.move_valid, 0);
        check("async_busy", bus.busy, 0);
        check("async_move_square", bus.move_square, 0);
        check("async_calc", {bus.square_calc, bus.piece_type_calc}, 0);
        check("async_count_done_init", {bus.move_count, bus.done, bus.init}, 0);
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            if (bus.done || bus.busy) done_cnt++;
            tick();
        end
        check("no_done_after_abort", done_cnt, 0);
        run_req(vecs[0].sq, vecs[0].pc, vecs[0].mb, vecs[0].occ, vecs[0].exp_mask, 0, 1'b0, 0);
        tick();

        // Randomized requests against the rule model.
        for (int n = 0; n < 40; n++) begin
            rpc = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 2) == 0) rpc = ($urandom_range(0, 1) != 0) ? 4'd11 : 4'd5;
            rsq = 6'($urandom);
            if (rpc == 4'd11 && $urandom_range(0, 1) != 0) rsq = 6'(8 + $urandom_range(0, 7));
            if (rpc == 4'd5  && $urandom_range(0, 1) != 0) rsq = 6'(48 + $urandom_range(0, 7));
            rmb  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            rocc = {$urandom, $urandom};
            if (rpc == 4'd11 && rsq < 6'd56 && $urandom_range(0, 1) != 0) rmb[rsq + 6'd8] = 1'b1;
            if (rpc == 4'd5  && rsq >= 6'd8 && $urandom_range(0, 1) != 0) rmb[rsq - 6'd8] = 1'b1;
            run_req(rsq, rpc, rmb, rocc, ref_mask(int'(rsq), int'(rpc), rmb, rocc),
                    $urandom_range(0, 3), 1'b1, 0);
            if ($urandom_range(0, 1) != 0) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
